// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle datapath controller: state codes, opcodes,
// ALU/mux select codes and the packed control-word layout.
package multicycle_control_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned ALUOP_W = 3;
    localparam int unsigned SEL_W   = 2;

    localparam logic [STATE_W-1:0] S_FETCH    = 4'd0;
    localparam logic [STATE_W-1:0] S_DECODE   = 4'd1;
    localparam logic [STATE_W-1:0] S_MEM_ADDR = 4'd2;
    localparam logic [STATE_W-1:0] S_MEM_RD   = 4'd3;
    localparam logic [STATE_W-1:0] S_MEM_WB   = 4'd4;
    localparam logic [STATE_W-1:0] S_MEM_WR   = 4'd5;
    localparam logic [STATE_W-1:0] S_EXEC_R   = 4'd6;
    localparam logic [STATE_W-1:0] S_R_WB     = 4'd7;
    localparam logic [STATE_W-1:0] S_EXEC_I   = 4'd8;
    localparam logic [STATE_W-1:0] S_I_WB     = 4'd9;
    localparam logic [STATE_W-1:0] S_BRANCH   = 4'd10;
    localparam logic [STATE_W-1:0] S_JUMP     = 4'd11;
    localparam logic [STATE_W-1:0] S_LUI_WB   = 4'd12;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0d;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0f;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2b;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;

    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 3'b111;
    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b100;
    localparam logic [ALUOP_W-1:0] ALUOP_OR    = 3'b101;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b010;
    localparam logic [ALUOP_W-1:0] ALUOP_NONE  = 3'b000;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_REGB  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMMSH = 2'b11;

    typedef struct packed {
        logic               pc_write;
        logic [SEL_W-1:0]   pc_source;
        logic               i_or_d;
        logic               mem_read;
        logic               mem_write;
        logic               ir_write;
        logic               alu_src_a;
        logic [SEL_W-1:0]   alu_src_b;
        logic [ALUOP_W-1:0] alu_op;
        logic               reg_write;
        logic               reg_dst;
        logic               mem_to_reg;
        logic               lui;
        logic               jal;
    } ctrl_t;

    // Dispatch target out of DECODE; unknown opcodes fall back to FETCH as a NOP.
    function automatic logic [STATE_W-1:0] decode_target(input logic [OP_W-1:0] op);
        case (op)
            OP_RTYPE:        decode_target = S_EXEC_R;
            OP_ADDI, OP_ORI: decode_target = S_EXEC_I;
            OP_LUI:          decode_target = S_LUI_WB;
            OP_LW, OP_SW:    decode_target = S_MEM_ADDR;
            OP_BEQ, OP_BNE:  decode_target = S_BRANCH;
            OP_J, OP_JAL:    decode_target = S_JUMP;
            default:         decode_target = S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller bundle: opcode/flag/handshake inputs and datapath control outputs.
interface multicycle_control_if;

    logic [multicycle_control_pkg::OP_W-1:0]    OP;
    logic                                       Zero;
    logic                                       mem_ready;
    logic                                       PCWrite;
    logic [multicycle_control_pkg::SEL_W-1:0]   PCSource;
    logic                                       IorD;
    logic                                       MemRead;
    logic                                       MemWrite;
    logic                                       IRWrite;
    logic                                       ALUSrcA;
    logic [multicycle_control_pkg::SEL_W-1:0]   ALUSrcB;
    logic [multicycle_control_pkg::ALUOP_W-1:0] ALUOp;
    logic                                       RegWrite;
    logic                                       RegDst;
    logic                                       MemtoReg;
    logic                                       Lui;
    logic                                       Jal;
    logic [multicycle_control_pkg::STATE_W-1:0] state_o;

    modport master (
        output OP, Zero, mem_ready,
        input  PCWrite, PCSource, IorD, MemRead, MemWrite, IRWrite, ALUSrcA, ALUSrcB,
               ALUOp, RegWrite, RegDst, MemtoReg, Lui, Jal, state_o
    );

    modport slave (
        input  OP, Zero, mem_ready,
        output PCWrite, PCSource, IorD, MemRead, MemWrite, IRWrite, ALUSrcA, ALUSrcB,
               ALUOp, RegWrite, RegDst, MemtoReg, Lui, Jal, state_o
    );

endinterface

// File: rtl/mc_next_state.sv
// Combinational next-state logic of the multicycle controller.
module mc_next_state
    import multicycle_control_pkg::*;
(
    input  logic [STATE_W-1:0] state_i,
    input  logic [OP_W-1:0]    op_i,
    input  logic               mem_ready_i,
    output logic [STATE_W-1:0] next_state_c_o
);

    always_comb begin
        next_state_c_o = S_FETCH;
        case (state_i)
            S_FETCH:    next_state_c_o = mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE:   next_state_c_o = decode_target(op_i);
            S_MEM_ADDR: next_state_c_o = (op_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   next_state_c_o = mem_ready_i ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   next_state_c_o = mem_ready_i ? S_FETCH : S_MEM_WR;
            S_EXEC_R:   next_state_c_o = S_R_WB;
            S_EXEC_I:   next_state_c_o = S_I_WB;
            // Write-back, branch, jump and unused codes all return to FETCH.
            default:    next_state_c_o = S_FETCH;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM: state register, next-state sub-block and
// combinational output decode gated off while reset is held.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.slave  bus
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    ctrl_t              ctrl_c;

    mc_next_state u_next_state (
        .state_i        (state_q),
        .op_i           (bus.OP),
        .mem_ready_i    (bus.mem_ready),
        .next_state_c_o (state_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Moore decode on state/OP; mem_ready and Zero are the only Mealy qualifiers.
    always_comb begin
        ctrl_c = '0;
        case (state_q)
            S_FETCH: begin
                ctrl_c.mem_read  = 1'b1;
                ctrl_c.alu_src_b = SRCB_FOUR;
                ctrl_c.alu_op    = ALUOP_ADD;
                ctrl_c.pc_source = PCSRC_ALU;
                ctrl_c.ir_write  = bus.mem_ready;
                ctrl_c.pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                ctrl_c.alu_src_b = SRCB_IMMSH;
                ctrl_c.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                ctrl_c.mem_read = 1'b1;
                ctrl_c.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_c.mem_write = 1'b1;
                ctrl_c.i_or_d    = 1'b1;
            end
            S_EXEC_R: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_REGB;
                ctrl_c.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.reg_dst   = 1'b1;
            end
            S_EXEC_I: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_op    = (bus.OP == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
            end
            S_I_WB:   ctrl_c.reg_write = 1'b1;
            S_LUI_WB: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.lui       = 1'b1;
            end
            S_BRANCH: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_REGB;
                ctrl_c.alu_op    = ALUOP_SUB;
                ctrl_c.pc_source = PCSRC_ALUOUT;
                ctrl_c.pc_write  = ((bus.OP == OP_BEQ) &&  bus.Zero) ||
                                   ((bus.OP == OP_BNE) && !bus.Zero);
            end
            S_JUMP: begin
                ctrl_c.pc_write  = 1'b1;
                ctrl_c.pc_source = PCSRC_JUMP;
                ctrl_c.reg_write = (bus.OP == OP_JAL);
                ctrl_c.jal       = (bus.OP == OP_JAL);
            end
            default: ctrl_c = '0;
        endcase
        if (!reset) ctrl_c = '0;
    end

    assign bus.PCWrite  = ctrl_c.pc_write;
    assign bus.PCSource = ctrl_c.pc_source;
    assign bus.IorD     = ctrl_c.i_or_d;
    assign bus.MemRead  = ctrl_c.mem_read;
    assign bus.MemWrite = ctrl_c.mem_write;
    assign bus.IRWrite  = ctrl_c.ir_write;
    assign bus.ALUSrcA  = ctrl_c.alu_src_a;
    assign bus.ALUSrcB  = ctrl_c.alu_src_b;
    assign bus.ALUOp    = ctrl_c.alu_op;
    assign bus.RegWrite = ctrl_c.reg_write;
    assign bus.RegDst   = ctrl_c.reg_dst;
    assign bus.MemtoReg = ctrl_c.mem_to_reg;
    assign bus.Lui      = ctrl_c.lui;
    assign bus.Jal      = ctrl_c.jal;
    assign bus.state_o  = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control: per-cycle state and control-word checks.
module tb_multicycle_control;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic [1:0] pcs;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       irw;
        logic       sa;
        logic [1:0] sb;
        logic [2:0] aop;
        logic       rw;
        logic       rd;
        logic       m2r;
        logic       lui;
        logic       jal;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    multicycle_control_if bus();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic obs_t observe();
        obs_t o;
        o.st   = bus.state_o;
        o.pcw  = bus.PCWrite;
        o.pcs  = bus.PCSource;
        o.iord = bus.IorD;
        o.mr   = bus.MemRead;
        o.mw   = bus.MemWrite;
        o.irw  = bus.IRWrite;
        o.sa   = bus.ALUSrcA;
        o.sb   = bus.ALUSrcB;
        o.aop  = bus.ALUOp;
        o.rw   = bus.RegWrite;
        o.rd   = bus.RegDst;
        o.m2r  = bus.MemtoReg;
        o.lui  = bus.Lui;
        o.jal  = bus.Jal;
        return o;
    endfunction

    function automatic obs_t fetch_exp(input logic rdy);
        obs_t e = '0;
        e.mr  = 1'b1;
        e.sb  = 2'b01;
        e.aop = 3'b100;
        e.irw = rdy;
        e.pcw = rdy;
        return e;
    endfunction

    function automatic obs_t decode_exp();
        obs_t e = '0;
        e.st  = 4'd1;
        e.sb  = 2'b11;
        e.aop = 3'b100;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got;
        bus.OP = 6'h00; bus.Zero = 1'b0; bus.mem_ready = 1'b1;
        #2 reset = 1'b0;
        #1;
        got = observe(); n_cmp++;
        if (got !== obs_t'(0)) begin n_err++; $display("FAIL reset_async: got %h want %h", got, obs_t'(0)); end
        for (int i = 0; i < 2; i++) begin
            tick();
            got = observe(); n_cmp++;
            if (got !== obs_t'(0)) begin n_err++; $display("FAIL reset_hold%0d: got %h want %h", i, got, obs_t'(0)); end
        end
        reset = 1'b1;
        #1;
        got = observe(); n_cmp++;
        if (got !== fetch_exp(1'b1)) begin n_err++; $display("FAIL reset_release: got %h want %h", got, fetch_exp(1'b1)); end
        bus.mem_ready = 1'b0;
        #1;
        got = observe(); n_cmp++;
        if (got !== fetch_exp(1'b0)) begin n_err++; $display("FAIL reset_fetch_wait: got %h want %h", got, fetch_exp(1'b0)); end
    endtask

    task automatic test_lw();
        obs_t e[6];
        obs_t got;
        e[0] = fetch_exp(1'b1);
        e[1] = decode_exp();
        e[2] = '0; e[2].st = 4'd2; e[2].sa = 1'b1; e[2].sb = 2'b10; e[2].aop = 3'b100;
        e[3] = '0; e[3].st = 4'd3; e[3].mr = 1'b1; e[3].iord = 1'b1;
        e[4] = '0; e[4].st = 4'd4; e[4].rw = 1'b1; e[4].m2r = 1'b1;
        e[5] = fetch_exp(1'b1);
        bus.OP = 6'h23; bus.mem_ready = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            got = observe(); n_cmp++;
            if (got !== e[i]) begin n_err++; $display("FAIL lw_c%0d: got %h want %h", i, got, e[i]); end
            if (i < 5) tick();
        end
    endtask

    task automatic test_alu_ops();
        obs_t e[$];
        obs_t x;
        obs_t got;
        logic [5:0] ops [4];
        ops = '{6'h00, 6'h08, 6'h0d, 6'h0f};
        for (int c = 0; c < 4; c++) begin
            e.delete();
            e.push_back(fetch_exp(1'b1));
            e.push_back(decode_exp());
            x = '0;
            case (c)
                0: begin
                    x.st = 4'd6; x.sa = 1'b1; x.aop = 3'b111; e.push_back(x);
                    x = '0; x.st = 4'd7; x.rw = 1'b1; x.rd = 1'b1; e.push_back(x);
                end
                1: begin
                    x.st = 4'd8; x.sa = 1'b1; x.sb = 2'b10; x.aop = 3'b100; e.push_back(x);
                    x = '0; x.st = 4'd9; x.rw = 1'b1; e.push_back(x);
                end
                2: begin
                    x.st = 4'd8; x.sa = 1'b1; x.sb = 2'b10; x.aop = 3'b101; e.push_back(x);
                    x = '0; x.st = 4'd9; x.rw = 1'b1; e.push_back(x);
                end
                default: begin
                    x.st = 4'd12; x.rw = 1'b1; x.lui = 1'b1; e.push_back(x);
                end
            endcase
            e.push_back(fetch_exp(1'b1));
            bus.OP = ops[c]; bus.mem_ready = 1'b1;
            #1;
            foreach (e[i]) begin
                got = observe(); n_cmp++;
                if (got !== e[i]) begin n_err++; $display("FAIL alu_op%h_c%0d: got %h want %h", ops[c], i, got, e[i]); end
                if (i < e.size() - 1) tick();
            end
        end
    endtask

    task automatic test_jump();
        obs_t e[4];
        obs_t got;
        for (int c = 0; c < 2; c++) begin
            e[0] = fetch_exp(1'b1);
            e[1] = decode_exp();
            e[2] = '0; e[2].st = 4'd11; e[2].pcw = 1'b1; e[2].pcs = 2'b10;
            e[2].rw = (c == 1); e[2].jal = (c == 1);
            e[3] = fetch_exp(1'b1);
            bus.OP = (c == 1) ? 6'h03 : 6'h02; bus.mem_ready = 1'b1;
            #1;
            for (int i = 0; i < 4; i++) begin
                got = observe(); n_cmp++;
                if (got !== e[i]) begin n_err++; $display("FAIL jump%0d_c%0d: got %h want %h", c, i, got, e[i]); end
                if (i < 3) tick();
            end
        end
    endtask

    task automatic test_branch();
        obs_t e;
        obs_t got;
        logic [5:0] op;
        for (int c = 0; c < 2; c++) begin
            op = (c == 0) ? 6'h04 : 6'h05;
            bus.OP = op; bus.Zero = 1'b1; bus.mem_ready = 1'b1;
            #1;
            tick();
            got = observe(); n_cmp++;
            if (got !== decode_exp()) begin n_err++; $display("FAIL br%h_decode: got %h want %h", op, got, decode_exp()); end
            tick();
            e = '0; e.st = 4'd10; e.sa = 1'b1; e.aop = 3'b010; e.pcs = 2'b01;
            e.pcw = (c == 0);
            got = observe(); n_cmp++;
            if (got !== e) begin n_err++; $display("FAIL br%h_zero1: got %h want %h", op, got, e); end
            bus.Zero = 1'b0;
            #1;
            e.pcw = (c == 1);
            got = observe(); n_cmp++;
            if (got !== e) begin n_err++; $display("FAIL br%h_zero0: got %h want %h", op, got, e); end
            tick();
            got = observe(); n_cmp++;
            if (got !== fetch_exp(1'b1)) begin n_err++; $display("FAIL br%h_return: got %h want %h", op, got, fetch_exp(1'b1)); end
        end
        bus.Zero = 1'b0;
    endtask

    task automatic test_illegal();
        obs_t got;
        bus.OP = 6'h3f; bus.mem_ready = 1'b1;
        #1;
        tick();
        got = observe(); n_cmp++;
        if (got !== decode_exp()) begin n_err++; $display("FAIL illegal_decode: got %h want %h", got, decode_exp()); end
        tick();
        got = observe(); n_cmp++;
        if (got !== fetch_exp(1'b1)) begin n_err++; $display("FAIL illegal_return: got %h want %h", got, fetch_exp(1'b1)); end
    endtask

    task automatic test_fetch_wait();
        obs_t got;
        obs_t e;
        bus.OP = 6'h3f; bus.mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            tick();
            got = observe(); n_cmp++;
            if (got !== fetch_exp(1'b0)) begin n_err++; $display("FAIL fetch_wait%0d: got %h want %h", i, got, fetch_exp(1'b0)); end
        end
        bus.mem_ready = 1'b1;
        bus.OP = 6'h0f;
        #1;
        got = observe(); n_cmp++;
        if (got !== fetch_exp(1'b1)) begin n_err++; $display("FAIL fetch_ready: got %h want %h", got, fetch_exp(1'b1)); end
        tick();
        tick();
        e = '0; e.st = 4'd12; e.rw = 1'b1; e.lui = 1'b1;
        got = observe(); n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL fetch_op_late: got %h want %h", got, e); end
        tick();
    endtask

    task automatic test_sw_wait();
        obs_t e;
        obs_t got;
        int   mw_cycles = 0;
        bus.OP = 6'h2b; bus.mem_ready = 1'b1;
        #1;
        tick();
        tick();
        e = '0; e.st = 4'd2; e.sa = 1'b1; e.sb = 2'b10; e.aop = 3'b100;
        got = observe(); n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL sw_addr: got %h want %h", got, e); end
        bus.mem_ready = 1'b0;
        e = '0; e.st = 4'd5; e.mw = 1'b1; e.iord = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i < 2) tick();
            else begin bus.mem_ready = 1'b1; #1; end
            got = observe(); n_cmp++;
            if (got.mw === 1'b1) mw_cycles++;
            if (got !== e) begin n_err++; $display("FAIL sw_wr%0d: got %h want %h", i, got, e); end
        end
        n_cmp++;
        if (mw_cycles !== 3) begin n_err++; $display("FAIL sw_memwrite_cycles: got %0d want 3", mw_cycles); end
        tick();
        got = observe(); n_cmp++;
        if (got !== fetch_exp(1'b1)) begin n_err++; $display("FAIL sw_return: got %h want %h", got, fetch_exp(1'b1)); end
    endtask

    task automatic test_reset_mid();
        obs_t e;
        obs_t got;
        bus.OP = 6'h2b; bus.mem_ready = 1'b1;
        #1;
        tick();
        tick();
        bus.mem_ready = 1'b0;
        tick();
        e = '0; e.st = 4'd5; e.mw = 1'b1; e.iord = 1'b1;
        got = observe(); n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL rmid_in_wr: got %h want %h", got, e); end
        #1 reset = 1'b0;
        #1;
        got = observe(); n_cmp++;
        if (got !== obs_t'(0)) begin n_err++; $display("FAIL rmid_async: got %h want %h", got, obs_t'(0)); end
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            got = observe(); n_cmp++;
            if (got !== obs_t'(0)) begin n_err++; $display("FAIL rmid_hold%0d: got %h want %h", i, got, obs_t'(0)); end
        end
        reset = 1'b1;
        #1;
        got = observe(); n_cmp++;
        if (got !== fetch_exp(1'b1)) begin n_err++; $display("FAIL rmid_release: got %h want %h", got, fetch_exp(1'b1)); end
        tick();
        got = observe(); n_cmp++;
        if (got !== decode_exp()) begin n_err++; $display("FAIL rmid_first_edge: got %h want %h", got, decode_exp()); end
        tick();
        tick();
        tick();
        got = observe(); n_cmp++;
        if (got !== fetch_exp(1'b1)) begin n_err++; $display("FAIL rmid_complete: got %h want %h", got, fetch_exp(1'b1)); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_alu_ops();
        test_jump();
        test_branch();
        test_illegal();
        test_fetch_wait();
        test_sw_wait();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters: none; all encodings are fixed constants in the shared package.
REQ-002 clk  input  1  single clock, all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-004 OP  input  6  opcode field, taken from the instruction register output.
REQ-005 Zero  input  1  ALU zero flag, used for branch resolution.
REQ-006 mem_ready  input  1  memory done; read data or write is complete in the same cycle.
REQ-007 PCWrite  output  1  unconditional PC load strobe.
REQ-008 PCSource  output  2  PC mux: 00 ALU result, 01 ALUOut register, 10 jump target.
REQ-009 IorD  output  1  memory address mux: 0 PC, 1 ALUOut.
REQ-010 MemRead, MemWrite, IRWrite  output  1 each  memory and instruction-register strobes.
REQ-011 ALUSrcA  output  1  0 PC, 1 register A.
REQ-012 ALUSrcB  output  2  00 reg B, 01 constant 4, 10 sign-extended immediate, 11 immediate<<2.
REQ-013 ALUOp  output  3  111 R-type funct, 100 add, 101 or, 010 subtract, 000 none.
REQ-014 RegWrite, RegDst, MemtoReg, Lui, Jal  output  1 each  register-file write controls.
REQ-015 state_o  output  4  current state code, for debug and bench visibility.

Function
REQ-016 FSM states and codes: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, R_WB=7, EXEC_I=8, I_WB=9, BRANCH=10, JUMP=11, LUI_WB=12.
REQ-017 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=100, PCSource=00.
  - While mem_ready=0: hold in FETCH, IRWrite=0, PCWrite=0.
  - While mem_ready=1: IRWrite=1 and PCWrite=1 in that cycle; next state DECODE.
REQ-018 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=100 (branch target into ALUOut); next state by OP:
  - 0x00 -> EXEC_R; 0x08 -> EXEC_I; 0x0d -> EXEC_I; 0x0f -> LUI_WB.
  - 0x23 -> MEM_ADDR; 0x2b -> MEM_ADDR.
  - 0x04 -> BRANCH; 0x05 -> BRANCH.
  - 0x02 -> JUMP; 0x03 -> JUMP.
  - any other opcode -> FETCH, with no side effects (executes as NOP).
REQ-019 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=100; next MEM_RD for 0x23, MEM_WR for 0x2b.
REQ-020 MEM_RD: MemRead=1, IorD=1; hold until mem_ready=1, then next MEM_WB.
REQ-021 MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0; next FETCH.
REQ-022 MEM_WR: MemWrite=1, IorD=1; hold until mem_ready=1, then next FETCH.
REQ-023 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=111; next R_WB. R_WB: RegWrite=1, RegDst=1; next FETCH.
REQ-024 EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=100 for 0x08 or 101 for 0x0d; next I_WB. I_WB: RegWrite=1, RegDst=0; next FETCH.
REQ-025 LUI_WB: RegWrite=1, Lui=1, RegDst=0; next FETCH.
REQ-026 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=010, PCSource=01.
  - PCWrite=1 iff (OP=0x04 and Zero=1) or (OP=0x05 and Zero=0).
  - Next state FETCH in either case.
REQ-027 JUMP: PCWrite=1, PCSource=10; additionally for OP=0x03, RegWrite=1 and Jal=1 (link register 31); next FETCH.
REQ-028 Decoded outputs are Moore functions of state and OP. The only Mealy terms are:
  - mem_ready qualifying IRWrite and PCWrite in FETCH;
  - Zero qualifying PCWrite in BRANCH.
REQ-029 Any signal not listed for a state is 0 in that state; undefined state codes 13-15 behave as FETCH with all strobes 0 and next state FETCH.
REQ-030 Cycle counts with mem_ready=1 throughout:
  - lw 5; sw 4; R-type 4; addi/ori 4; lui 3; branch 3; j/jal 3.
  - Each cycle with mem_ready=0 adds one cycle.
REQ-031 OP is sampled only in DECODE through REQ-027; OP changes while in FETCH have no effect.

Reset
REQ-032 reset=0 forces state FETCH asynchronously; all strobe outputs are 0 while reset=0.
REQ-033 Reset asserted mid-instruction (for example in MEM_WR) aborts the instruction; no further MemWrite, PCWrite or RegWrite is issued.
REQ-034 After reset release, the first rising edge evaluates FETCH normally.

Structure
REQ-035 A shared package holds the state encodings, the opcode constants (0x00, 0x08, 0x0d, 0x0f, 0x04, 0x05, 0x23, 0x2b, 0x02, 0x03), the ALUOp codes, and the PCSource/ALUSrcB encodings.
REQ-036 One sub-module, mc_next_state (combinational next-state logic from state, OP, mem_ready), is instantiated alongside the state register and the output decode.

Verification
REQ-037 lw (OP=0x23), mem_ready=1 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-038 sw (OP=0x2b), mem_ready low for 2 cycles in MEM_WR -> MemWrite=1 held for 3 cycles; return to FETCH after the mem_ready=1 cycle.
REQ-039 beq (0x04) with Zero=1 -> PCWrite=1, PCSource=01 in BRANCH; bne (0x05) with Zero=1 -> PCWrite=0.
REQ-040 jal (0x03) -> JUMP with PCWrite=1, PCSource=10, RegWrite=1, Jal=1; 3 cycles total.
REQ-041 Illegal OP=0x3f -> DECODE then FETCH, with no RegWrite, MemWrite or PCWrite issued in DECODE.
REQ-042 reset=0 asserted during MEM_WR -> state_o=0 and MemWrite=0 immediately, without waiting for a clock edge.
